arf_sequencer: RTL and testbench

Command-driven sequencer for the address register file (PC, AR, SP). Accepts one stack/program-flow command at a time over a valid/ready handshake. Expands each command into a fixed multi-cycle sequence of FunSel/RegSel/OutCSel/OutDSel controls and memory read/write strobes. Sits between the instruction control unit and the address register file; it also drives the file's 16-bit I input.

---
 rtl/arf_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_arf_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arf_sequencer.sv
// arf_sequencer: expands PC/AR/SP stack and program-flow commands into
// multi-cycle control sequences for the address register file.
// Optional build macro: ARF_SEQ_STACK_CHECK_EN adds a stack depth tracker
// that turns overflowing pushes and underflowing pops into a one-cycle error.
module arf_sequencer #(
    parameter int unsigned Depth = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid_i,
    input  logic [2:0]  cmd_op_i,
    input  logic [15:0] cmd_data_i,
    input  logic [15:0] mem_data_i,
    output logic        cmd_ready_o,
    output logic        done_o,
    output logic        err_o,
    output logic [15:0] arf_i_o,
    output logic [2:0]  fun_sel_o,
    output logic [2:0]  reg_sel_o,
    output logic [1:0]  out_c_sel_o,
    output logic [1:0]  out_d_sel_o,
    output logic        mem_read_o,
    output logic        mem_write_o
);

    localparam logic [2:0] OpNop    = 3'b000;
    localparam logic [2:0] OpFetch  = 3'b001;
    localparam logic [2:0] OpJump   = 3'b010;
    localparam logic [2:0] OpPush   = 3'b011;
    localparam logic [2:0] OpPop    = 3'b100;
    localparam logic [2:0] OpCall   = 3'b101;
    localparam logic [2:0] OpRet    = 3'b110;
    localparam logic [2:0] OpLoadAr = 3'b111;

    localparam logic [2:0] FunDec  = 3'b000;
    localparam logic [2:0] FunInc  = 3'b001;
    localparam logic [2:0] FunLoad = 3'b010;

    // Active-low register enables: bit2 PC, bit1 AR, bit0 SP
    localparam logic [2:0] EnNone = 3'b111;
    localparam logic [2:0] EnPc   = 3'b011;
    localparam logic [2:0] EnAr   = 3'b101;
    localparam logic [2:0] EnSp   = 3'b110;

    localparam logic [1:0] SelPc = 2'b00;
    localparam logic [1:0] SelSp = 2'b11;

    typedef enum logic [4:0] {
        StIdle, StN0, StF0, StF1, StJ0, StL0, StP0, StP1, StQ0, StQ1,
        StC0, StC1, StC2, StR0, StR1, StR2
`ifdef ARF_SEQ_STACK_CHECK_EN
        , StE0
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] data_q;

    logic [2:0] reg_sel_d, fun_sel_d;
    logic [1:0] out_c_sel_d, out_d_sel_d;
    logic       mem_read_d, mem_write_d, done_d, ready_d;

`ifdef ARF_SEQ_STACK_CHECK_EN
    localparam int unsigned DepthW = $clog2(Depth + 1);
    localparam logic [DepthW-1:0] DepthMax = DepthW'(Depth);

    logic [DepthW-1:0] depth_q;
    logic              err_q, err_d;
    logic              stack_viol;

    // Overflow/underflow test against the depth seen at acceptance
    always_comb begin
        stack_viol = 1'b0;
        if ((cmd_op_i == OpPush || cmd_op_i == OpCall) && depth_q == DepthMax) begin
            stack_viol = 1'b1;
        end
        if ((cmd_op_i == OpPop || cmd_op_i == OpRet) && depth_q == '0) begin
            stack_viol = 1'b1;
        end
    end

    assign err_o = err_q;
`else
    logic [31:0] unused_depth;
    assign unused_depth = Depth;
    assign err_o        = 1'b0;
`endif

    // Next state: one state per cycle, final states fall back to idle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    unique case (cmd_op_i)
                        OpNop:    state_d = StN0;
                        OpFetch:  state_d = StF0;
                        OpJump:   state_d = StJ0;
                        OpPush:   state_d = StP0;
                        OpPop:    state_d = StQ0;
                        OpCall:   state_d = StC0;
                        OpRet:    state_d = StR0;
                        OpLoadAr: state_d = StL0;
                    endcase
`ifdef ARF_SEQ_STACK_CHECK_EN
                    if (stack_viol) state_d = StE0;
`endif
                end
            end
            StF0:    state_d = StF1;
            StP0:    state_d = StP1;
            StQ0:    state_d = StQ1;
            StC0:    state_d = StC1;
            StC1:    state_d = StC2;
            StR0:    state_d = StR1;
            StR1:    state_d = StR2;
            default: state_d = StIdle;
        endcase
    end

    // Control decode of the state about to be entered, so outputs are registered
    always_comb begin
        reg_sel_d   = EnNone;
        fun_sel_d   = FunDec;
        out_c_sel_d = SelPc;
        out_d_sel_d = SelPc;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        done_d      = 1'b0;
        ready_d     = 1'b0;
`ifdef ARF_SEQ_STACK_CHECK_EN
        err_d       = 1'b0;
`endif
        unique case (state_d)
            StIdle: ready_d = 1'b1;
            StN0:   done_d = 1'b1;
            StF0:   mem_read_d = 1'b1;
            StF1:   begin reg_sel_d = EnPc; fun_sel_d = FunInc; done_d = 1'b1; end
            StJ0:   begin reg_sel_d = EnPc; fun_sel_d = FunLoad; done_d = 1'b1; end
            StL0:   begin reg_sel_d = EnAr; fun_sel_d = FunLoad; done_d = 1'b1; end
            StP0:   begin reg_sel_d = EnSp; fun_sel_d = FunDec; end
            StP1:   begin out_d_sel_d = SelSp; mem_write_d = 1'b1; done_d = 1'b1; end
            StQ0:   begin out_d_sel_d = SelSp; mem_read_d = 1'b1; end
            StQ1:   begin reg_sel_d = EnSp; fun_sel_d = FunInc; done_d = 1'b1; end
            StC0:   begin reg_sel_d = EnSp; fun_sel_d = FunDec; end
            StC1:   begin out_d_sel_d = SelSp; out_c_sel_d = SelPc; mem_write_d = 1'b1; end
            StC2:   begin reg_sel_d = EnPc; fun_sel_d = FunLoad; done_d = 1'b1; end
            StR0:   begin out_d_sel_d = SelSp; mem_read_d = 1'b1; end
            StR1:   begin reg_sel_d = EnPc; fun_sel_d = FunLoad; end
            StR2:   begin reg_sel_d = EnSp; fun_sel_d = FunInc; done_d = 1'b1; end
`ifdef ARF_SEQ_STACK_CHECK_EN
            StE0:   begin err_d = 1'b1; done_d = 1'b1; end
`endif
            default: ;
        endcase
    end

    // I input: zero when idle, popped return address in R1, else the latched operand
    always_comb begin
        arf_i_o = data_q;
        if (state_q == StIdle) begin
            arf_i_o = '0;
        end else if (state_q == StR1) begin
            arf_i_o = mem_data_i;
        end
    end

    // State, operand latch, registered controls and optional depth tracker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            data_q      <= '0;
            reg_sel_o   <= EnNone;
            fun_sel_o   <= FunDec;
            out_c_sel_o <= SelPc;
            out_d_sel_o <= SelPc;
            mem_read_o  <= 1'b0;
            mem_write_o <= 1'b0;
            done_o      <= 1'b0;
            cmd_ready_o <= 1'b1;
`ifdef ARF_SEQ_STACK_CHECK_EN
            err_q       <= 1'b0;
            depth_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            reg_sel_o   <= reg_sel_d;
            fun_sel_o   <= fun_sel_d;
            out_c_sel_o <= out_c_sel_d;
            out_d_sel_o <= out_d_sel_d;
            mem_read_o  <= mem_read_d;
            mem_write_o <= mem_write_d;
            done_o      <= done_d;
            cmd_ready_o <= ready_d;
            if (cmd_valid_i && cmd_ready_o) begin
                data_q <= cmd_data_i;
            end
`ifdef ARF_SEQ_STACK_CHECK_EN
            err_q <= err_d;
            if (state_q == StP1 || state_q == StC2) begin
                depth_q <= depth_q + 1'b1;
            end else if (state_q == StQ1 || state_q == StR2) begin
                depth_q <= depth_q - 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_arf_sequencer.sv
// Bench for arf_sequencer: a behavioural register file and memory react to the
// DUT controls, while an architectural model predicts per-cycle controls and
// the PC/AR/SP/memory state each command should leave behind.
`timescale 1ns/1ps
module tb_arf_sequencer;

`ifdef ARF_SEQ_STACK_CHECK_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 16;
`endif

    localparam logic [2:0] NOP = 3'd0, FETCH = 3'd1, JUMP = 3'd2, PUSH = 3'd3;
    localparam logic [2:0] POP = 3'd4, CALL = 3'd5, RET = 3'd6, LOADAR = 3'd7;
    localparam logic [2:0] DEC = 3'd0, INC = 3'd1, LOAD = 3'd2;

    typedef struct packed {
        logic [2:0]  rs;
        logic [2:0]  fs;
        logic [1:0]  oc;
        logic [1:0]  od;
        logic        mr;
        logic        mw;
        logic        done;
        logic        err;
        logic [15:0] arfi;
    } ctl_t;

    localparam ctl_t IDLE_CTL = ctl_t'({3'b111, 27'b0});

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_op = 3'd0;
    logic [15:0] cmd_data = 16'h0;
    logic [15:0] mem_data = 16'h0;
    logic        cmd_ready, done, err, mem_read, mem_write;
    logic [15:0] arf_i;
    logic [2:0]  fun_sel, reg_sel;
    logic [1:0]  out_c_sel, out_d_sel;

    arf_sequencer #(.Depth(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_op_i    (cmd_op),
        .cmd_data_i  (cmd_data),
        .mem_data_i  (mem_data),
        .cmd_ready_o (cmd_ready),
        .done_o      (done),
        .err_o       (err),
        .arf_i_o     (arf_i),
        .fun_sel_o   (fun_sel),
        .reg_sel_o   (reg_sel),
        .out_c_sel_o (out_c_sel),
        .out_d_sel_o (out_d_sel),
        .mem_read_o  (mem_read),
        .mem_write_o (mem_write)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    ctl_t exp_q[$];

    // Register file and memory driven by the DUT controls
    logic [15:0] m_pc = 16'h0010, m_ar = 16'h0000, m_sp = 16'h0100;
    logic [15:0] tmem [0:65535] = '{default: 16'h0};

    // Architectural expectation
    logic [15:0] g_pc = 16'h0010, g_ar = 16'h0000, g_sp = 16'h0100;
    logic [15:0] gmem [0:65535] = '{default: 16'h0};
    int          g_depth = 0;

    function automatic logic [15:0] pick(input logic [1:0] sel);
        case (sel)
            2'b10:   return m_ar;
            2'b11:   return m_sp;
            default: return m_pc;
        endcase
    endfunction

    function automatic logic [15:0] upd(input logic [15:0] v, input logic [2:0] f,
                                        input logic [15:0] ld);
        case (f)
            DEC:     return v - 16'd1;
            INC:     return v + 16'd1;
            LOAD:    return ld;
            default: return v;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!reg_sel[2]) m_pc <= upd(m_pc, fun_sel, arf_i);
        if (!reg_sel[1]) m_ar <= upd(m_ar, fun_sel, arf_i);
        if (!reg_sel[0]) m_sp <= upd(m_sp, fun_sel, arf_i);
        if (mem_write) tmem[pick(out_d_sel)] <= pick(out_c_sel);
        if (mem_read) mem_data <= tmem[pick(out_d_sel)];
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic ctl_t mk(input logic [2:0] rs, input logic [2:0] fs,
                                input logic [1:0] od, input logic mr, input logic mw,
                                input logic dn, input logic [15:0] a);
        ctl_t c;
        c = IDLE_CTL;
        c.rs = rs; c.fs = fs; c.od = od; c.mr = mr; c.mw = mw; c.done = dn; c.arfi = a;
        return c;
    endfunction

    // Predict the per-cycle controls and the architectural effect of one command
    function automatic bit accept(input logic [2:0] op, input logic [15:0] d);
        ctl_t e;
        bit   viol = 1'b0;
`ifdef ARF_SEQ_STACK_CHECK_EN
        if ((op == PUSH || op == CALL) && g_depth == int'(DEPTH)) viol = 1'b1;
        if ((op == POP || op == RET) && g_depth == 0) viol = 1'b1;
`endif
        if (viol) begin
            e = mk(3'b111, DEC, 2'b00, 0, 0, 1, d);
            e.err = 1'b1;
            exp_q.push_back(e);
            return 1'b1;
        end
        case (op)
            NOP: exp_q.push_back(mk(3'b111, DEC, 2'b00, 0, 0, 1, d));
            FETCH: begin
                exp_q.push_back(mk(3'b111, DEC, 2'b00, 1, 0, 0, d));
                exp_q.push_back(mk(3'b011, INC, 2'b00, 0, 0, 1, d));
                g_pc = g_pc + 16'd1;
            end
            JUMP: begin
                exp_q.push_back(mk(3'b011, LOAD, 2'b00, 0, 0, 1, d));
                g_pc = d;
            end
            LOADAR: begin
                exp_q.push_back(mk(3'b101, LOAD, 2'b00, 0, 0, 1, d));
                g_ar = d;
            end
            PUSH: begin
                exp_q.push_back(mk(3'b110, DEC, 2'b00, 0, 0, 0, d));
                exp_q.push_back(mk(3'b111, DEC, 2'b11, 0, 1, 1, d));
                g_sp = g_sp - 16'd1;
                gmem[g_sp] = g_pc;
                g_depth++;
            end
            POP: begin
                exp_q.push_back(mk(3'b111, DEC, 2'b11, 1, 0, 0, d));
                exp_q.push_back(mk(3'b110, INC, 2'b00, 0, 0, 1, d));
                g_sp = g_sp + 16'd1;
                g_depth--;
            end
            CALL: begin
                exp_q.push_back(mk(3'b110, DEC, 2'b00, 0, 0, 0, d));
                exp_q.push_back(mk(3'b111, DEC, 2'b11, 0, 1, 0, d));
                exp_q.push_back(mk(3'b011, LOAD, 2'b00, 0, 0, 1, d));
                g_sp = g_sp - 16'd1;
                gmem[g_sp] = g_pc;
                g_pc = d;
                g_depth++;
            end
            default: begin  // RET
                exp_q.push_back(mk(3'b111, DEC, 2'b11, 1, 0, 0, d));
                exp_q.push_back(mk(3'b011, LOAD, 2'b00, 0, 0, 0, gmem[g_sp]));
                exp_q.push_back(mk(3'b110, INC, 2'b00, 0, 0, 1, d));
                g_pc = gmem[g_sp];
                g_sp = g_sp + 16'd1;
                g_depth--;
            end
        endcase
        return 1'b0;
    endfunction

    // Monitor: pop one expectation per busy cycle, check idle state otherwise
    ctl_t mon_got, mon_exp;
    always @(negedge clk) begin
        if (rst_n) begin
            mon_got = {reg_sel, fun_sel, out_c_sel, out_d_sel, mem_read, mem_write,
                       done, err, arf_i};
            if (!cmd_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL busy_extra: got busy cycle %0h want idle at %0t",
                             mon_got, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("ctl", mon_got, mon_exp);
                end
            end else begin
                check("idle_ctl", mon_got, IDLE_CTL);
                check("idle_pending", exp_q.size(), 0);
                check("arch_pc", m_pc, g_pc);
                check("arch_ar", m_ar, g_ar);
                check("arch_sp", m_sp, g_sp);
            end
        end
    end

    // One stimulus cycle, driven 2 ns after the falling edge
    task automatic step(input logic v, input logic [2:0] op, input logic [15:0] d,
                        output bit acc, output bit viol);
        @(negedge clk);
        #2;
        cmd_valid = v;
        cmd_op    = op;
        cmd_data  = d;
        acc       = v && cmd_ready;
        viol      = acc ? accept(op, d) : 1'b0;
    endtask

    task automatic idle(input int n);
        bit a, b;
        for (int i = 0; i < n; i++) step(1'b0, NOP, 16'h0, a, b);
    endtask

    initial begin
        bit          acc, viol, last_viol;
        int          last_acc;
        logic [15:0] s_pc, s_sp, s_mem;

        #1 rst_n = 1'b0;
        #7;
        check("rst_regsel", reg_sel, 3'b111);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_arfi", arf_i, 16'h0);
        check("rst_mem", {mem_read, mem_write}, 2'b00);
        #14 rst_n = 1'b1;

        // CALL 0x1234 from PC=0x0010, SP=0x0100, then RET
        step(1'b1, CALL, 16'h1234, acc, viol);
        idle(4);
        check("call_pc", m_pc, 16'h1234);
        check("call_sp", m_sp, 16'h00FF);
        check("call_mem", tmem[16'h00FF], 16'h0010);
        step(1'b1, RET, 16'($urandom), acc, viol);
        idle(4);
        check("ret_pc", m_pc, 16'h0010);
        check("ret_sp", m_sp, 16'h0100);

        step(1'b1, JUMP, 16'h0040, acc, viol);
        idle(2);
        step(1'b1, FETCH, 16'($urandom), acc, viol);
        idle(3);
        check("fetch_pc", m_pc, 16'h0041);

        // POP x3 from an empty stack
        for (int i = 0; i < 3; i++) begin
            step(1'b1, POP, 16'($urandom), acc, viol);
            idle(3);
        end

        // Reset while in C1 of a CALL
        s_pc  = g_pc;
        s_sp  = g_sp;
        s_mem = gmem[g_sp - 16'd1];
        step(1'b1, CALL, 16'hBEEF, acc, viol);
        step(1'b0, NOP, 16'h0, acc, viol);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_regsel", reg_sel, 3'b111);
        check("midrst_memwr", mem_write, 1'b0);
        check("midrst_ready", cmd_ready, 1'b1);
        check("midrst_done", done, 1'b0);
        exp_q.delete();
        g_pc = s_pc;
        g_sp = s_sp - 16'd1;  // only the C0 decrement took effect
        gmem[s_sp - 16'd1] = s_mem;
        g_depth = 0;
        @(posedge clk);
        #2;
        check("midrst2_regsel", reg_sel, 3'b111);
        check("midrst2_memwr", mem_write, 1'b0);
        check("midrst2_ready", cmd_ready, 1'b1);
        #1 rst_n = 1'b1;

        // CmdValid held high with PUSH
        last_acc  = -1;
        last_viol = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step(1'b1, PUSH, 16'($urandom), acc, viol);
            if (acc) begin
                if (last_acc >= 0) check("push_gap", i - last_acc, last_viol ? 2 : 3);
                last_acc  = i;
                last_viol = viol;
            end
        end
        idle(4);

        // Random traffic, valid also asserted while busy
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom),
                 acc, viol);
        end
        idle(6);
        check("drain_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
